// File: rtl/handshake_pkg.sv
// Shared definitions for the dataflow handshake library (fork, join, mux units).
package handshake_pkg;

  localparam int unsigned DefaultDataType = 32;
  localparam int unsigned MaxBusWidth     = 1024;
  localparam int unsigned MaxSliceWidth   = 256;

  // Returns slice idx of a packed bus made of equal-width fields, zero-extended.
  function automatic logic [MaxSliceWidth-1:0] bus_slice(input logic [MaxBusWidth-1:0] bus,
                                                         input int unsigned width,
                                                         input int unsigned idx);
    logic [MaxBusWidth-1:0]   shifted;
    logic [MaxSliceWidth-1:0] res;
    shifted = bus >> (idx * width);
    res     = '0;
    for (int unsigned b = 0; b < MaxSliceWidth; b++) begin
      if (b < width) res[b] = shifted[b];
    end
    return res;
  endfunction

endpackage

// File: rtl/handshake_eager_fork_if.sv
// Handshake bundle for the eager fork: one input channel, SIZE output channels.
interface handshake_eager_fork_if
  import handshake_pkg::*;
#(
  parameter int unsigned DATA_TYPE = DefaultDataType,
  parameter int unsigned SIZE      = 2
) ();

  logic [DATA_TYPE-1:0]      ins;
  logic                      ins_valid;
  logic                      ins_ready;
  logic [SIZE*DATA_TYPE-1:0] outs;
  logic [SIZE-1:0]           outs_valid;
  logic [SIZE-1:0]           outs_ready;

  // Producer and consumers drive the bundle from the master side.
  modport master (
    output ins, ins_valid, outs_ready,
    input  ins_ready, outs, outs_valid
  );

  modport slave (
    input  ins, ins_valid, outs_ready,
    output ins_ready, outs, outs_valid
  );

endinterface

// File: rtl/handshake_eager_fork_reg_block.sv
// Single-output cell of the eager fork: remembers whether this output took the current token.
module eager_fork_reg_block (
  input  logic clk,
  input  logic rst,
  input  logic fwd_valid,
  input  logic outs_ready,
  input  logic retire,
  output logic outs_valid,
  output logic done
);

  logic sent_q, sent_d;

  always_comb begin
    outs_valid = fwd_valid & ~sent_q;
    done       = sent_q | outs_ready;
    sent_d     = sent_q;
    if (retire) begin
      sent_d = 1'b0;
    end else if (outs_valid && outs_ready) begin
      sent_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sent_q <= 1'b0;
    end else begin
      sent_q <= sent_d;
    end
  end

endmodule

// File: rtl/handshake_eager_fork.sv
// Eager fork: copies one token to SIZE consumers, each accepting independently.
// Define HANDSHAKE_EAGER_FORK_INBUF_EN to insert a one-slot input register before the fork.
module handshake_eager_fork
  import handshake_pkg::*;
#(
  parameter int unsigned DATA_TYPE = DefaultDataType,
  parameter int unsigned SIZE      = 2
) (
  input logic                   clk,
  input logic                   rst,
  handshake_eager_fork_if.slave bus
);

  logic                 fwd_valid;
  logic                 fwd_ready;
  logic                 retire;
  logic [DATA_TYPE-1:0] fwd_data;
  logic [SIZE-1:0]      done;
  logic [SIZE-1:0]      valid_vec;

  for (genvar g = 0; g < SIZE; g++) begin : g_cell
    eager_fork_reg_block u_cell (
      .clk        (clk),
      .rst        (rst),
      .fwd_valid  (fwd_valid),
      .outs_ready (bus.outs_ready[g]),
      .retire     (retire),
      .outs_valid (valid_vec[g]),
      .done       (done[g])
    );
  end

  assign fwd_ready      = &done;
  assign retire         = fwd_valid & fwd_ready;
  assign bus.outs_valid = valid_vec;
  assign bus.outs       = {SIZE{fwd_data}};

`ifdef HANDSHAKE_EAGER_FORK_INBUF_EN
  logic                 slot_full_q, slot_full_d;
  logic [DATA_TYPE-1:0] slot_data_q, slot_data_d;

  // Slot accepts a new token whenever it is empty or its token retires this cycle.
  assign bus.ins_ready = ~slot_full_q | fwd_ready;
  assign fwd_valid     = slot_full_q;
  assign fwd_data      = slot_data_q;

  always_comb begin
    slot_full_d = slot_full_q;
    slot_data_d = slot_data_q;
    if (bus.ins_valid && bus.ins_ready) begin
      slot_full_d = 1'b1;
      slot_data_d = bus.ins;
    end else if (retire) begin
      slot_full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_full_q <= 1'b0;
      slot_data_q <= '0;
    end else begin
      slot_full_q <= slot_full_d;
      slot_data_q <= slot_data_d;
    end
  end
`else
  assign fwd_valid     = bus.ins_valid;
  assign fwd_data      = bus.ins;
  assign bus.ins_ready = fwd_ready;
`endif

endmodule

// File: tb/tb_handshake_eager_fork.sv
// Scoreboard bench for handshake_eager_fork with a SIZE=2 and a SIZE=3 instance.
module tb_handshake_eager_fork;
  import handshake_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [31:0] exp2[2][$];
  logic [31:0] obs2[2][$];
  logic [31:0] exp3[3][$];
  logic [31:0] obs3[3][$];

  always #5 clk = ~clk;

  handshake_eager_fork_if #(.DATA_TYPE(32), .SIZE(2)) b2 ();
  handshake_eager_fork_if #(.DATA_TYPE(32), .SIZE(3)) b3 ();

  handshake_eager_fork #(.DATA_TYPE(32), .SIZE(2)) dut2 (.clk(clk), .rst(rst), .bus(b2));
  handshake_eager_fork #(.DATA_TYPE(32), .SIZE(3)) dut3 (.clk(clk), .rst(rst), .bus(b3));

  function automatic logic [31:0] sl2(input int unsigned i);
    logic [MaxBusWidth-1:0]   w;
    logic [MaxSliceWidth-1:0] s;
    w       = '0;
    w[63:0] = b2.outs;
    s       = bus_slice(w, 32, i);
    return s[31:0];
  endfunction

  function automatic logic [31:0] sl3(input int unsigned i);
    logic [MaxBusWidth-1:0]   w;
    logic [MaxSliceWidth-1:0] s;
    w       = '0;
    w[95:0] = b3.outs;
    s       = bus_slice(w, 32, i);
    return s[31:0];
  endfunction

  // Records each output handshake just before the edge that completes it, then steps one cycle.
  task automatic tick();
    @(negedge clk);
    if (!rst) begin
      for (int i = 0; i < 2; i++)
        if (b2.outs_valid[i] && b2.outs_ready[i]) obs2[i].push_back(sl2(i));
      for (int i = 0; i < 3; i++)
        if (b3.outs_valid[i] && b3.outs_ready[i]) obs3[i].push_back(sl3(i));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    b2.ins = 32'h1234; b2.ins_valid = 1'b1; b2.outs_ready = 2'b10;
    b3.ins = '0; b3.ins_valid = 1'b0; b3.outs_ready = 3'b111;
    #1;
`ifdef HANDSHAKE_EAGER_FORK_INBUF_EN
    n_cmp++;
    if (b2.outs_valid !== 2'b00) begin
      n_err++; $display("FAIL reset_valid got %b want 00", b2.outs_valid);
    end
    n_cmp++;
    if (b2.ins_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_ready got %b want 1", b2.ins_ready);
    end
`else
    n_cmp++;
    if (b2.outs_valid !== 2'b11) begin
      n_err++; $display("FAIL reset_valid got %b want 11", b2.outs_valid);
    end
    n_cmp++;
    if (b2.ins_ready !== 1'b0) begin
      n_err++; $display("FAIL reset_ready got %b want 0", b2.ins_ready);
    end
`endif
    n_cmp++;
    if (b3.outs_valid !== 3'b000) begin
      n_err++; $display("FAIL reset_valid3 got %b want 000", b3.outs_valid);
    end
    @(posedge clk); #1;
    b2.ins_valid = 1'b0;
    rst = 1'b0;
    #1;
  endtask

`ifdef HANDSHAKE_EAGER_FORK_INBUF_EN
  task automatic test_inbuf();
    logic [31:0] toks[5];
    toks = '{32'h7, 32'h8, 32'h9, 32'hA, 32'hB};
    b2.outs_ready = 2'b11;
    n_cmp++;
    if (b2.ins_ready !== 1'b1) begin
      n_err++; $display("FAIL inbuf_idle_ready got %b want 1", b2.ins_ready);
    end
    for (int k = 0; k < 3; k++) begin
      b2.ins = toks[k]; b2.ins_valid = 1'b1; #1;
      exp2[0].push_back(toks[k]); exp2[1].push_back(toks[k]);
      n_cmp++;
      if (b2.outs_valid !== ((k == 0) ? 2'b00 : 2'b11)) begin
        n_err++; $display("FAIL inbuf_stream_valid k=%0d got %b", k, b2.outs_valid);
      end
      n_cmp++;
      if (b2.ins_ready !== 1'b1) begin
        n_err++; $display("FAIL inbuf_stream_ready k=%0d got %b want 1", k, b2.ins_ready);
      end
      tick();
    end
    b2.ins_valid = 1'b0; #1;
    n_cmp++;
    if (b2.outs_valid !== 2'b11 || sl2(0) !== 32'h9) begin
      n_err++; $display("FAIL inbuf_tail got %b/%h want 11/9", b2.outs_valid, sl2(0));
    end
    tick();
    b2.outs_ready = 2'b00; b2.ins = toks[3]; b2.ins_valid = 1'b1; #1;
    exp2[0].push_back(toks[3]); exp2[1].push_back(toks[3]);
    n_cmp++;
    if (b2.ins_ready !== 1'b1) begin
      n_err++; $display("FAIL inbuf_empty_ready got %b want 1", b2.ins_ready);
    end
    tick();
    b2.ins = toks[4]; #1;
    exp2[0].push_back(toks[4]); exp2[1].push_back(toks[4]);
    for (int c = 0; c < 2; c++) begin
      n_cmp++;
      if (b2.ins_ready !== 1'b0 || b2.outs_valid !== 2'b11) begin
        n_err++; $display("FAIL inbuf_full c=%0d got rdy=%b v=%b want 0/11", c, b2.ins_ready,
                          b2.outs_valid);
      end
      tick();
    end
    b2.outs_ready = 2'b11; #1;
    n_cmp++;
    if (b2.ins_ready !== 1'b1) begin
      n_err++; $display("FAIL inbuf_refill_ready got %b want 1", b2.ins_ready);
    end
    tick();
    b2.ins_valid = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (obs2[i].size() !== exp2[i].size()) begin
        n_err++; $display("FAIL inbuf_count out%0d got %0d want %0d", i, obs2[i].size(),
                          exp2[i].size());
      end
      while (exp2[i].size() > 0 && obs2[i].size() > 0) begin
        logic [31:0] e, o;
        e = exp2[i].pop_front(); o = obs2[i].pop_front();
        n_cmp++;
        if (o !== e) begin
          n_err++; $display("FAIL inbuf_data out%0d got %h want %h", i, o, e);
        end
      end
      exp2[i].delete(); obs2[i].delete();
    end
  endtask
`else
  task automatic test_all_ready();
    b2.ins = 32'hA5A5_0001; b2.ins_valid = 1'b1; b2.outs_ready = 2'b11; #1;
    exp2[0].push_back(32'hA5A5_0001); exp2[1].push_back(32'hA5A5_0001);
    n_cmp++;
    if (b2.outs_valid !== 2'b11 || b2.ins_ready !== 1'b1) begin
      n_err++; $display("FAIL all_ready got v=%b r=%b want 11/1", b2.outs_valid, b2.ins_ready);
    end
    n_cmp++;
    if (sl2(0) !== 32'hA5A5_0001 || sl2(1) !== 32'hA5A5_0001) begin
      n_err++; $display("FAIL all_ready_data got %h/%h want a5a50001", sl2(0), sl2(1));
    end
    tick();
    b2.ins = 32'hA5A5_0002; #1;
    exp2[0].push_back(32'hA5A5_0002); exp2[1].push_back(32'hA5A5_0002);
    n_cmp++;
    if (b2.outs_valid !== 2'b11) begin
      n_err++; $display("FAIL all_ready_sent_clear got %b want 11", b2.outs_valid);
    end
    tick();
    b2.ins_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (obs2[i].size() !== exp2[i].size()) begin
        n_err++; $display("FAIL all_ready_count out%0d got %0d want %0d", i, obs2[i].size(),
                          exp2[i].size());
      end
      while (exp2[i].size() > 0 && obs2[i].size() > 0) begin
        logic [31:0] e, o;
        e = exp2[i].pop_front(); o = obs2[i].pop_front();
        n_cmp++;
        if (o !== e) begin
          n_err++; $display("FAIL all_ready_data out%0d got %h want %h", i, o, e);
        end
      end
      exp2[i].delete(); obs2[i].delete();
    end
  endtask

  task automatic test_staggered();
    b2.ins = 32'hBEEF_0002; b2.ins_valid = 1'b1; b2.outs_ready = 2'b01; #1;
    exp2[0].push_back(32'hBEEF_0002); exp2[1].push_back(32'hBEEF_0002);
    n_cmp++;
    if (b2.ins_ready !== 1'b0 || b2.outs_valid !== 2'b11) begin
      n_err++; $display("FAIL stag_c0 got r=%b v=%b want 0/11", b2.ins_ready, b2.outs_valid);
    end
    tick();
    b2.outs_ready = 2'b10; #1;
    n_cmp++;
    if (b2.outs_valid !== 2'b10 || b2.ins_ready !== 1'b1) begin
      n_err++; $display("FAIL stag_c1 got v=%b r=%b want 10/1", b2.outs_valid, b2.ins_ready);
    end
    b2.outs_ready = 2'b11; #1;
    n_cmp++;
    if (b2.outs_valid !== 2'b10) begin
      n_err++; $display("FAIL stag_no_reoffer got %b want 10", b2.outs_valid);
    end
    tick();
    b2.ins_valid = 1'b0; b2.outs_ready = 2'b00;
    tick();
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (obs2[i].size() !== exp2[i].size()) begin
        n_err++; $display("FAIL stag_count out%0d got %0d want %0d", i, obs2[i].size(),
                          exp2[i].size());
      end
      while (exp2[i].size() > 0 && obs2[i].size() > 0) begin
        logic [31:0] e, o;
        e = exp2[i].pop_front(); o = obs2[i].pop_front();
        n_cmp++;
        if (o !== e) begin
          n_err++; $display("FAIL stag_data out%0d got %h want %h", i, o, e);
        end
      end
      exp2[i].delete(); obs2[i].delete();
    end
  endtask

  task automatic test_back_to_back();
    b2.outs_ready = 2'b11;
    for (int k = 1; k <= 3; k++) begin
      b2.ins = 32'(k); b2.ins_valid = 1'b1; #1;
      exp2[0].push_back(32'(k)); exp2[1].push_back(32'(k));
      n_cmp++;
      if (b2.ins_ready !== 1'b1 || b2.outs_valid !== 2'b11) begin
        n_err++; $display("FAIL b2b k=%0d got r=%b v=%b want 1/11", k, b2.ins_ready,
                          b2.outs_valid);
      end
      tick();
    end
    b2.ins_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (obs2[i].size() !== exp2[i].size()) begin
        n_err++; $display("FAIL b2b_count out%0d got %0d want %0d", i, obs2[i].size(),
                          exp2[i].size());
      end
      while (exp2[i].size() > 0 && obs2[i].size() > 0) begin
        logic [31:0] e, o;
        e = exp2[i].pop_front(); o = obs2[i].pop_front();
        n_cmp++;
        if (o !== e) begin
          n_err++; $display("FAIL b2b_data out%0d got %h want %h", i, o, e);
        end
      end
      exp2[i].delete(); obs2[i].delete();
    end
  endtask

  task automatic test_stall3();
    b3.ins = 32'h33; b3.ins_valid = 1'b1; b3.outs_ready = 3'b011; #1;
    for (int i = 0; i < 3; i++) exp3[i].push_back(32'h33);
    n_cmp++;
    if (b3.ins_ready !== 1'b0) begin
      n_err++; $display("FAIL stall3_c0 got r=%b want 0", b3.ins_ready);
    end
    tick();
    for (int c = 1; c <= 5; c++) begin
      if (c == 5) b3.outs_ready = 3'b111;
      #1;
      n_cmp++;
      if (b3.outs_valid !== 3'b100 || b3.ins_ready !== (c == 5)) begin
        n_err++; $display("FAIL stall3 c=%0d got v=%b r=%b want 100/%0d", c, b3.outs_valid,
                          b3.ins_ready, (c == 5));
      end
      tick();
    end
    b3.ins = 32'h44; #1;
    for (int i = 0; i < 3; i++) exp3[i].push_back(32'h44);
    n_cmp++;
    if (b3.outs_valid !== 3'b111) begin
      n_err++; $display("FAIL stall3_next got %b want 111", b3.outs_valid);
    end
    tick();
    b3.ins_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (obs3[i].size() !== exp3[i].size()) begin
        n_err++; $display("FAIL stall3_count out%0d got %0d want %0d", i, obs3[i].size(),
                          exp3[i].size());
      end
      while (exp3[i].size() > 0 && obs3[i].size() > 0) begin
        logic [31:0] e, o;
        e = exp3[i].pop_front(); o = obs3[i].pop_front();
        n_cmp++;
        if (o !== e) begin
          n_err++; $display("FAIL stall3_data out%0d got %h want %h", i, o, e);
        end
      end
      exp3[i].delete(); obs3[i].delete();
    end
  endtask

  task automatic test_reset_mid();
    b2.ins = 32'h55; b2.ins_valid = 1'b1; b2.outs_ready = 2'b01; #1;
    exp2[0].push_back(32'h55);
    tick();
    b2.outs_ready = 2'b00; #1;
    n_cmp++;
    if (b2.outs_valid !== 2'b10) begin
      n_err++; $display("FAIL rst_mid_pre got %b want 10", b2.outs_valid);
    end
    rst = 1'b1; #1;
    n_cmp++;
    if (b2.outs_valid !== 2'b11) begin
      n_err++; $display("FAIL rst_mid_async got %b want 11", b2.outs_valid);
    end
    tick();
    rst = 1'b0; #1;
    n_cmp++;
    if (b2.outs_valid !== 2'b11) begin
      n_err++; $display("FAIL rst_mid_after got %b want 11", b2.outs_valid);
    end
    b2.outs_ready = 2'b11; #1;
    exp2[0].push_back(32'h55); exp2[1].push_back(32'h55);
    n_cmp++;
    if (b2.ins_ready !== 1'b1) begin
      n_err++; $display("FAIL rst_mid_retire got %b want 1", b2.ins_ready);
    end
    tick();
    b2.ins_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (obs2[i].size() !== exp2[i].size()) begin
        n_err++; $display("FAIL rst_mid_count out%0d got %0d want %0d", i, obs2[i].size(),
                          exp2[i].size());
      end
      while (exp2[i].size() > 0 && obs2[i].size() > 0) begin
        logic [31:0] e, o;
        e = exp2[i].pop_front(); o = obs2[i].pop_front();
        n_cmp++;
        if (o !== e) begin
          n_err++; $display("FAIL rst_mid_data out%0d got %h want %h", i, o, e);
        end
      end
      exp2[i].delete(); obs2[i].delete();
    end
  endtask
`endif

  initial begin
    test_reset();
`ifdef HANDSHAKE_EAGER_FORK_INBUF_EN
    test_inbuf();
`else
    test_all_ready();
    test_staggered();
    test_back_to_back();
    test_stall3();
    test_reset_mid();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
